sc_timing_gen: RTL and testbench
================================

Name: sc_timing_gen

Overview:
Parametrised output-side timing generator and line-buffer read-address sequencer, successor to the fixed-width scanconverter output logic. Runs entirely in the output pixel clock domain. Generates HSYNC/VSYNC/DE and a border mask, and produces the line-buffer read address with independent X/Y repeat and skip. Resynchronises to the capture-side frame boundary. Sync/DE outputs are delay-matched to the line-buffer read latency, so downstream logic sees aligned pixel data and timing.

Parameters:
H_W, 12, width of horizontal counter and H_TOTAL
V_W, 11, width of vertical counter and V_TOTAL/V_STARTLINE
X_W, 11, width of buffer x address
LB_ROWS_LOG2, 3, log2 of line-buffer row count; row field width of read address
RPT_W, 3, width of repeat/skip fields
RD_LATENCY, 1, line-buffer read latency in cycles (1..4) that timing outputs are delayed to match

Ports:
PCLK_OUT_i  in  1  output pixel clock
reset_n  in  1  asynchronous active-low reset
frame_change_i  in  1  capture-domain frame toggle/level; synchronised internally with 2 flops
h_synclen_i  in  9  hsync width
h_backporch_i  in  9  h back porch
h_active_i  in  X_W  h active pixels
h_total_i  in  H_W  pixels per line
v_synclen_i  in  5  vsync width in lines
v_backporch_i  in  9  v back porch
v_active_i  in  V_W  active lines
v_total_i  in  V_W  lines per frame
v_startline_i  in  V_W  line loaded on resync
x_start_i  in  9  first output pixel (relative to active start) reading buffer x=0
y_start_i  in  9  first active line reading buffer row 0
x_rpt_i / y_rpt_i  in  RPT_W  each source pixel/line is output rpt+1 times
x_skip_i / y_skip_i  in  RPT_W  source pixels/lines skipped per step
lb_rdaddr_o  out  LB_ROWS_LOG2+X_W  {ypos[LB_ROWS_LOG2-1:0], xpos}
HSYNC_o  out  1  active-low hsync
VSYNC_o  out  1  active-low vsync
DE_o  out  1  data enable
mask_o  out  1  high inside DE but before image start (x_start/y_start border)
resync_strobe_o  out  1  one-cycle pulse on each resync
resync_cnt_o  out  8  saturating resync count

Behaviour:
- Reset (async assert, sync release): h_cnt=0, v_cnt=0, xpos=ypos=0, x_ctr=y_ctr=0. HSYNC_o=1, VSYNC_o=1, DE_o=0, mask_o=0, resync_strobe_o=0, resync_cnt_o=0, lb_rdaddr_o=0. The sync and delay pipelines clear to their idle values.
- h_cnt increments every cycle. When h_cnt >= h_total_i-1 (>= so a runtime shrink wraps immediately): h_cnt<=0 and v_cnt advances.
- v_cnt wraps to 0 when v_cnt >= v_total_i-1.
- Resync: fires on a rising edge of the synchronised frame_change, unless v_cnt equals v_startline_i or v_startline_i-1. The predecessor is computed modulo v_total_i, so v_startline_i=0 excludes v_total_i-1.
  - On resync: h_cnt<=0, v_cnt<=v_startline_i, resync_strobe_o=1 for exactly 1 cycle, resync_cnt_o+=1 (saturates at 255).
  - Resync overrides a simultaneous wrap.
- Timing, stage 0 (registered from the counters):
  - hs = h_cnt>=h_synclen
  - vs = v_cnt>=v_synclen
  - de = h in [HS+HBP, HS+HBP+HACT) and v in [VS+VBP, VS+VBP+VACT)
  - mask = de & (h < HS+HBP+x_start or v < VS+VBP+y_start)
- Timing delay: stage-0 values pass through RD_LATENCY further register stages before HSYNC_o/VSYNC_o/DE_o/mask_o. Total latency from counters is RD_LATENCY+1 cycles.
- Address, at h_cnt == HS+HBP+x_start-1:
  - xpos<=0, x_ctr<=0.
  - If v_cnt == VS+VBP+y_start: ypos<=0, y_ctr<=0.
  - Otherwise, if y_ctr==y_rpt: ypos+=1+y_skip and y_ctr<=0; else y_ctr+=1.
- Address, all other cycles: if x_ctr==x_rpt, xpos+=1+x_skip and x_ctr<=0; else x_ctr+=1.
- Wrap rules: xpos wraps modulo 2^X_W; the ypos row field wraps modulo 2^LB_ROWS_LOG2. All sums are computed at counter width +1 to avoid silent truncation in comparisons.
- lb_rdaddr_o is registered and has zero added latency relative to xpos/ypos.
- Config changes apply immediately; no shadowing.

Decomposition:
- Package sc_pkg: default widths, SYNC_STAGES=2, RESYNC_CNT_MAX=255, and the typedef of the timing bundle {hs,vs,de,mask}.
- Sub-module sc_delay_line (parametrised width and depth shift register with async reset) is used for the RD_LATENCY alignment.

Test Plan:
- Reset then 480p (h 62/60/720/858, v 6/30/480/525), RD_LATENCY=1 -> HSYNC_o low for cycles 2..63 after release; 345600 DE cycles per frame; VSYNC_o low for 6 lines.
- frame_change rises at v_cnt=100 with v_startline=5 -> 2 sync cycles later h_cnt=0, v_cnt=5, strobe high 1 cycle, resync_cnt_o=1. A further edge at v_cnt=4 or 5 is ignored.
- v_startline=0, edge at v_cnt=524 -> no resync. Edge at v_cnt=200 -> v_cnt=0.
- x_rpt=1, x_skip=0 -> x field 0,0,1,1,2,2. x_rpt=0, x_skip=1 -> 0,2,4. x_start=10 -> x=0 on first DE cycle+10, and mask_o high for first 10 DE cycles.
- y_rpt=2, LB_ROWS_LOG2=3 -> row field 0,0,0,1,1,1,... wraps 7->0 after 24 lines.
- h_total changed 858->700 while h_cnt=800 -> next cycle h_cnt=0, v_cnt+1, no X/Z on any output.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared widths, constants and the timing bundle for the scanconverter output timing generator.
package sc_pkg;

  localparam int unsigned H_W_DEF          = 12;
  localparam int unsigned V_W_DEF          = 11;
  localparam int unsigned X_W_DEF          = 11;
  localparam int unsigned LB_ROWS_LOG2_DEF = 3;
  localparam int unsigned RPT_W_DEF        = 3;
  localparam int unsigned RD_LATENCY_DEF   = 1;

  localparam int unsigned SYNC_STAGES      = 2;
  localparam int unsigned RESYNC_CNT_W     = 8;
  localparam int unsigned RESYNC_CNT_MAX   = 255;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic mask;
  } timing_t;

  localparam timing_t TIMING_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, mask: 1'b0};

endpackage

// File: rtl/sc_delay_line.sv
// Fixed-depth shift register with async reset to a configurable idle value.
module sc_delay_line #(
  parameter int unsigned      WIDTH   = 4,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/sc_timing_gen.sv
// Output pixel-clock timing generator: HSYNC/VSYNC/DE/mask plus line-buffer read address
// with independent X/Y repeat and skip, resynchronised to the capture frame boundary.
module sc_timing_gen
  import sc_pkg::*;
#(
  parameter int unsigned H_W          = H_W_DEF,
  parameter int unsigned V_W          = V_W_DEF,
  parameter int unsigned X_W          = X_W_DEF,
  parameter int unsigned LB_ROWS_LOG2 = LB_ROWS_LOG2_DEF,
  parameter int unsigned RPT_W        = RPT_W_DEF,
  parameter int unsigned RD_LATENCY   = RD_LATENCY_DEF
) (
  input  logic                        PCLK_OUT_i,
  input  logic                        reset_n,
  input  logic                        frame_change_i,
  input  logic [8:0]                  h_synclen_i,
  input  logic [8:0]                  h_backporch_i,
  input  logic [X_W-1:0]              h_active_i,
  input  logic [H_W-1:0]              h_total_i,
  input  logic [4:0]                  v_synclen_i,
  input  logic [8:0]                  v_backporch_i,
  input  logic [V_W-1:0]              v_active_i,
  input  logic [V_W-1:0]              v_total_i,
  input  logic [V_W-1:0]              v_startline_i,
  input  logic [8:0]                  x_start_i,
  input  logic [8:0]                  y_start_i,
  input  logic [RPT_W-1:0]            x_rpt_i,
  input  logic [RPT_W-1:0]            y_rpt_i,
  input  logic [RPT_W-1:0]            x_skip_i,
  input  logic [RPT_W-1:0]            y_skip_i,
  output logic [LB_ROWS_LOG2+X_W-1:0] lb_rdaddr_o,
  output logic                        HSYNC_o,
  output logic                        VSYNC_o,
  output logic                        DE_o,
  output logic                        mask_o,
  output logic                        resync_strobe_o,
  output logic [7:0]                  resync_cnt_o
);

  localparam int unsigned HX_W = H_W + 1;
  localparam int unsigned VX_W = V_W + 1;

  logic [H_W-1:0]          h_cnt;
  logic [V_W-1:0]          v_cnt;
  logic [SYNC_STAGES-1:0]  fc_sync;
  logic                    fc_prev;
  logic [X_W-1:0]          xpos;
  logic [LB_ROWS_LOG2-1:0] ypos;
  logic [RPT_W-1:0]        x_ctr;
  logic [RPT_W-1:0]        y_ctr;
  logic [RESYNC_CNT_W-1:0] resync_cnt;
  logic                    resync_strobe;
  timing_t                 t0;
  timing_t                 t0_q;
  timing_t                 t_dly;

  logic [HX_W-1:0] h_ext, h_de_start, h_de_end, h_img;
  logic [VX_W-1:0] v_ext, v_de_start, v_de_end, v_img;
  logic [V_W-1:0]  v_pred;
  logic            h_wrap, v_wrap, fc_rise, resync, x_trig, y_home;

  // Window boundaries, widened by one bit so sums never truncate before comparing
  assign h_ext      = HX_W'(h_cnt);
  assign v_ext      = VX_W'(v_cnt);
  assign h_de_start = HX_W'(h_synclen_i) + HX_W'(h_backporch_i);
  assign h_de_end   = h_de_start + HX_W'(h_active_i);
  assign h_img      = h_de_start + HX_W'(x_start_i);
  assign v_de_start = VX_W'(v_synclen_i) + VX_W'(v_backporch_i);
  assign v_de_end   = v_de_start + VX_W'(v_active_i);
  assign v_img      = v_de_start + VX_W'(y_start_i);

  assign h_wrap = (h_ext + HX_W'(1)) >= HX_W'(h_total_i);
  assign v_wrap = (v_ext + VX_W'(1)) >= VX_W'(v_total_i);

  // Line before the start line, taken modulo the frame length
  assign v_pred  = (v_startline_i == '0) ? v_total_i - V_W'(1) : v_startline_i - V_W'(1);
  assign fc_rise = fc_sync[SYNC_STAGES-1] & ~fc_prev;
  assign resync  = fc_rise & (v_cnt != v_startline_i) & (v_cnt != v_pred);

  assign x_trig = (h_ext + HX_W'(1)) == h_img;
  assign y_home = v_ext == v_img;

  always_ff @(posedge PCLK_OUT_i or negedge reset_n) begin
    if (!reset_n) begin
      fc_sync <= '0;
      fc_prev <= 1'b0;
    end else begin
      fc_sync <= {fc_sync[SYNC_STAGES-2:0], frame_change_i};
      fc_prev <= fc_sync[SYNC_STAGES-1];
    end
  end

  // Raster counters; a resync takes priority over the natural wrap
  always_ff @(posedge PCLK_OUT_i or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (resync) begin
      h_cnt <= '0;
      v_cnt <= v_startline_i;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + V_W'(1);
    end else begin
      h_cnt <= h_cnt + H_W'(1);
    end
  end

  always_ff @(posedge PCLK_OUT_i or negedge reset_n) begin
    if (!reset_n) begin
      resync_strobe <= 1'b0;
      resync_cnt    <= '0;
    end else begin
      resync_strobe <= resync;
      if (resync && resync_cnt != RESYNC_CNT_W'(RESYNC_CNT_MAX))
        resync_cnt <= resync_cnt + RESYNC_CNT_W'(1);
    end
  end

  always_comb begin
    t0      = TIMING_IDLE;
    t0.hs   = h_ext >= HX_W'(h_synclen_i);
    t0.vs   = v_ext >= VX_W'(v_synclen_i);
    t0.de   = (h_ext >= h_de_start) && (h_ext < h_de_end) &&
              (v_ext >= v_de_start) && (v_ext < v_de_end);
    t0.mask = t0.de && ((h_ext < h_img) || (v_ext < v_img));
  end

  always_ff @(posedge PCLK_OUT_i or negedge reset_n) begin
    if (!reset_n) t0_q <= TIMING_IDLE;
    else          t0_q <= t0;
  end

  // Align sync/DE with the line-buffer read data
  sc_delay_line #(
    .WIDTH   ($bits(timing_t)),
    .DEPTH   (RD_LATENCY),
    .RST_VAL (TIMING_IDLE)
  ) u_delay (
    .clk   (PCLK_OUT_i),
    .rst_n (reset_n),
    .d     (t0_q),
    .q     (t_dly)
  );

  // Read address: restart x one cycle ahead of the image, step y once per line
  always_ff @(posedge PCLK_OUT_i or negedge reset_n) begin
    if (!reset_n) begin
      xpos  <= '0;
      ypos  <= '0;
      x_ctr <= '0;
      y_ctr <= '0;
    end else if (x_trig) begin
      xpos  <= '0;
      x_ctr <= '0;
      if (y_home) begin
        ypos  <= '0;
        y_ctr <= '0;
      end else if (y_ctr == y_rpt_i) begin
        ypos  <= ypos + LB_ROWS_LOG2'(y_skip_i) + LB_ROWS_LOG2'(1);
        y_ctr <= '0;
      end else begin
        y_ctr <= y_ctr + RPT_W'(1);
      end
    end else if (x_ctr == x_rpt_i) begin
      xpos  <= xpos + X_W'(x_skip_i) + X_W'(1);
      x_ctr <= '0;
    end else begin
      x_ctr <= x_ctr + RPT_W'(1);
    end
  end

  assign lb_rdaddr_o     = {ypos, xpos};
  assign HSYNC_o         = t_dly.hs;
  assign VSYNC_o         = t_dly.vs;
  assign DE_o            = t_dly.de;
  assign mask_o          = t_dly.mask;
  assign resync_strobe_o = resync_strobe;
  assign resync_cnt_o    = resync_cnt;

endmodule

// File: tb/tb_sc_timing_gen.sv
// Randomised and directed checks of sc_timing_gen against a closed-form raster/address model.
module tb_sc_timing_gen;

  localparam int unsigned H_W = 12, V_W = 11, X_W = 11, LB_ROWS_LOG2 = 3, RPT_W = 3;
  localparam int unsigned RD_LATENCY = 1;
  localparam int unsigned AW = LB_ROWS_LOG2 + X_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_change;
  logic [8:0] h_synclen, h_backporch, x_start, y_start, v_backporch;
  logic [X_W-1:0] h_active;
  logic [H_W-1:0] h_total;
  logic [4:0] v_synclen;
  logic [V_W-1:0] v_active, v_total, v_startline;
  logic [RPT_W-1:0] x_rpt, y_rpt, x_skip, y_skip;
  logic [AW-1:0] rdaddr;
  logic hsync, vsync, de, mask, strobe;
  logic [7:0] rcnt;

  int tests = 0;
  int failed = 0;

  // Reference model state
  int m_h, m_v, m_nx, m_ny, m_rcnt;
  bit m_strobe, fc0, fc1, fc2;
  logic [3:0] m_dq [RD_LATENCY+1];

  always #5 clk = ~clk;

  sc_timing_gen #(
    .H_W(H_W), .V_W(V_W), .X_W(X_W), .LB_ROWS_LOG2(LB_ROWS_LOG2),
    .RPT_W(RPT_W), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .PCLK_OUT_i(clk), .reset_n(rst_n), .frame_change_i(frame_change),
    .h_synclen_i(h_synclen), .h_backporch_i(h_backporch), .h_active_i(h_active),
    .h_total_i(h_total), .v_synclen_i(v_synclen), .v_backporch_i(v_backporch),
    .v_active_i(v_active), .v_total_i(v_total), .v_startline_i(v_startline),
    .x_start_i(x_start), .y_start_i(y_start), .x_rpt_i(x_rpt), .y_rpt_i(y_rpt),
    .x_skip_i(x_skip), .y_skip_i(y_skip), .lb_rdaddr_o(rdaddr), .HSYNC_o(hsync),
    .VSYNC_o(vsync), .DE_o(de), .mask_o(mask), .resync_strobe_o(strobe),
    .resync_cnt_o(rcnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {5'b0, hsync, vsync, de, mask, strobe, rcnt, rdaddr};
  endfunction

  // Address is a closed form of cycles/lines elapsed since the last restart
  function automatic logic [31:0] exp_vec();
    int xv, yv;
    xv = ((m_nx / (int'(x_rpt) + 1)) * (int'(x_skip) + 1)) % (1 << X_W);
    yv = ((m_ny / (int'(y_rpt) + 1)) * (int'(y_skip) + 1)) % (1 << LB_ROWS_LOG2);
    return {5'b0, m_dq[RD_LATENCY], m_strobe, 8'(m_rcnt), 3'(yv), 11'(xv)};
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_nx = 0; m_ny = 0; m_rcnt = 0;
    m_strobe = 0; fc0 = 0; fc1 = 0; fc2 = 0;
    for (int i = 0; i <= RD_LATENCY; i++) m_dq[i] = 4'b1100;
  endtask

  task automatic model_step();
    int hs_a, hbp, hact, htot, vs_a, vbp, vact, vtot, vst, xst, yst, pred;
    bit rise, rs, d0, trig;
    hs_a = int'(h_synclen); hbp = int'(h_backporch); hact = int'(h_active);
    htot = int'(h_total);   vs_a = int'(v_synclen);  vbp = int'(v_backporch);
    vact = int'(v_active);  vtot = int'(v_total);    vst = int'(v_startline);
    xst = int'(x_start);    yst = int'(y_start);
    rise = fc1 && !fc2;
    pred = (vst == 0) ? vtot - 1 : vst - 1;
    d0 = (m_h >= hs_a + hbp) && (m_h < hs_a + hbp + hact) &&
         (m_v >= vs_a + vbp) && (m_v < vs_a + vbp + vact);
    for (int i = RD_LATENCY; i > 0; i--) m_dq[i] = m_dq[i-1];
    m_dq[0] = {m_h >= hs_a, m_v >= vs_a, d0,
               d0 && (m_h < hs_a + hbp + xst || m_v < vs_a + vbp + yst)};
    trig = (m_h + 1 == hs_a + hbp + xst);
    if (trig) begin
      m_nx = 0;
      if (m_v == vs_a + vbp + yst) m_ny = 0;
      else m_ny++;
    end else begin
      m_nx++;
    end
    rs = rise && (m_v != vst) && (m_v != pred);
    m_strobe = rs;
    if (rs && m_rcnt < 255) m_rcnt++;
    if (rs) begin
      m_h = 0; m_v = vst;
    end else if (m_h + 1 >= htot) begin
      m_h = 0; m_v = (m_v + 1 >= vtot) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
    fc2 = fc1; fc1 = fc0; fc0 = frame_change;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("outs", dut_vec(), exp_vec());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_change = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset", dut_vec(), {5'b0, 4'b1100, 1'b0, 8'd0, 14'd0});
    rst_n = 1'b1;
  endtask

  task automatic wait_vh(input int v, input int h, input int max_cyc);
    int n = 0;
    while (!((v < 0 || m_v == v) && m_h == h) && n < max_cyc) begin
      tick();
      n++;
    end
    check("wait_vh", 32'((v < 0 || m_v == v) && m_h == h), 32'd1);
  endtask

  task automatic set_cfg(input int hs_a, input int hbp, input int hact, input int htot,
                         input int vs_a, input int vbp, input int vact, input int vtot);
    h_synclen = 9'(hs_a); h_backporch = 9'(hbp); h_active = X_W'(hact); h_total = H_W'(htot);
    v_synclen = 5'(vs_a); v_backporch = 9'(vbp); v_active = V_W'(vact); v_total = V_W'(vtot);
    x_start = '0; y_start = '0; x_rpt = '0; y_rpt = '0; x_skip = '0; y_skip = '0;
    v_startline = '0;
  endtask

  task automatic frame_count(input int exp_de, input int exp_mask);
    int n_de = 0, n_mask = 0, period;
    period = int'(h_total) * int'(v_total);
    repeat (period) tick();
    for (int i = 0; i < period; i++) begin
      tick();
      if (de) n_de++;
      if (mask) n_mask++;
    end
    check("de_per_frame", 32'(n_de), 32'(exp_de));
    check("mask_per_frame", 32'(n_mask), 32'(exp_mask));
  endtask

  task automatic pulse_fc_at(input int v, input int max_cyc);
    frame_change = 1'b0;
    repeat (4) tick();
    wait_vh(v, 2, max_cyc);
    frame_change = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    int first_low, hs_low, vs_low, hv, vv, hsv;
    logic [X_W-1:0] xf;
    logic [LB_ROWS_LOG2-1:0] yf;
    int exp_x1 [6] = '{0, 0, 1, 1, 2, 2};
    int exp_x2 [3] = '{0, 2, 4};

    // 480p raster: hsync/vsync widths after reset, then a runtime h_total shrink
    frame_change = 1'b0;
    set_cfg(62, 60, 720, 858, 6, 30, 480, 525);
    do_reset();
    first_low = -1; hs_low = 0; vs_low = 0;
    for (int k = 1; k <= 7 * 858; k++) begin
      tick();
      if (k <= 858 && !hsync) begin
        hs_low++;
        if (first_low < 0) first_low = k;
      end
      if (!vsync) vs_low++;
    end
    check("hs_first_low", 32'(first_low), 32'd2);
    check("hs_low_width", 32'(hs_low), 32'd62);
    check("vs_low_cycles", 32'(vs_low), 32'(6 * 858));
    wait_vh(-1, 800, 900);
    h_total = H_W'(700);
    repeat (8) begin
      tick();
      check("no_x", 32'($isunknown(dut_vec())), 32'd0);
    end

    // Resync: accepted edge, excluded lines, start line 0 wrapping exclusion
    set_cfg(4, 4, 16, 32, 2, 2, 20, 30);
    v_startline = V_W'(5);
    do_reset();
    pulse_fc_at(10, 2000);
    check("resync_first", 32'(rcnt), 32'd1);
    pulse_fc_at(4, 2000);
    check("resync_pred_ignored", 32'(rcnt), 32'd1);
    pulse_fc_at(5, 2000);
    check("resync_start_ignored", 32'(rcnt), 32'd1);
    v_startline = '0;
    pulse_fc_at(29, 2000);
    check("resync_wrap_ignored", 32'(rcnt), 32'd1);
    pulse_fc_at(15, 2000);
    check("resync_to_zero", 32'(rcnt), 32'd2);
    frame_change = 1'b0;
    repeat (40) tick();

    // X repeat, Y repeat with row wrap, DE/mask per frame
    set_cfg(3, 3, 12, 24, 2, 2, 30, 40);
    x_start = 9'd2; y_start = 9'd3; x_rpt = 3'd1; y_rpt = 3'd2;
    do_reset();
    hv = 3 + 3 + 2;
    wait_vh(-1, hv, 100);
    for (int i = 0; i < 6; i++) begin
      xf = rdaddr[X_W-1:0];
      check("x_rpt1", 32'(xf), 32'(exp_x1[i]));
      tick();
    end
    vv = 2 + 2 + 3;
    wait_vh(vv, hv, 2000);
    for (int k = 0; k < 26; k++) begin
      yf = rdaddr[AW-1:X_W];
      check("y_rpt2", 32'(yf), 32'((k / 3) % 8));
      repeat (24) tick();
    end
    frame_count(12 * 30, 3 * 12 + 27 * 2);

    // X skip with a wide left border
    set_cfg(3, 3, 12, 24, 2, 2, 30, 40);
    x_start = 9'd10; y_start = 9'd3; x_skip = 3'd1;
    do_reset();
    hv = 3 + 3 + 10;
    wait_vh(-1, hv, 100);
    for (int i = 0; i < 3; i++) begin
      xf = rdaddr[X_W-1:0];
      check("x_skip1", 32'(xf), 32'(exp_x2[i]));
      tick();
    end
    frame_count(12 * 30, 3 * 12 + 27 * 10);

    // Random configurations with sporadic frame_change activity
    for (int s = 0; s < 6; s++) begin
      hsv = int'($urandom_range(1, 8));
      set_cfg(hsv, int'($urandom_range(1, 8)), int'($urandom_range(8, 40)), 0,
              int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
              int'($urandom_range(5, 20)), 0);
      h_total = H_W'(int'(h_synclen) + int'(h_backporch) + int'(h_active) +
                     int'($urandom_range(2, 10)));
      v_total = V_W'(int'(v_synclen) + int'(v_backporch) + int'(v_active) +
                     int'($urandom_range(2, 5)));
      v_startline = V_W'($urandom_range(0, int'(v_total) - 1));
      x_start = 9'($urandom_range(0, 12)); y_start = 9'($urandom_range(0, 4));
      x_rpt = RPT_W'($urandom_range(0, 7)); y_rpt = RPT_W'($urandom_range(0, 7));
      x_skip = RPT_W'($urandom_range(0, 7)); y_skip = RPT_W'($urandom_range(0, 7));
      do_reset();
      for (int k = 0; k < 4000; k++) begin
        if ($urandom_range(0, 199) == 0) frame_change = ~frame_change;
        tick();
      end
    end

    // Resync counter saturation
    set_cfg(2, 2, 8, 16, 1, 1, 4, 10);
    v_startline = V_W'(3);
    do_reset();
    for (int k = 0; k < 7500; k++) begin
      if (k % 4 == 0) frame_change = ~frame_change;
      tick();
    end
    check("rcnt_saturate", 32'(rcnt), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
